// File: rtl/fourier_pkg.sv
// Shared constants, reciprocal table and FSM encoding for the Fourier harmonic sequencer.
package fourier_pkg;

    localparam int NORM_GAIN  = 160;
    localparam int NORM_SHIFT = 10;
    localparam int OUT_OFFSET = 120;
    localparam int OUT_RESET  = 128;

    // round(1024 / (2i+1)): amplitude of the i-th odd harmonic of a square wave
    localparam int RECIP [16] = '{
        1024, 341, 205, 146, 114, 93, 79, 68,
        60,   54,  49,  45,  41,  38, 35, 33
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/fourier_term_scaler.sv
// Scales one signed LUT sample by the reciprocal weight of its harmonic index.
module fourier_term_scaler
    import fourier_pkg::*;
(
    input  logic signed [8:0]  i_lutData,
    input  logic        [3:0]  i_harmIdx,
    output logic signed [15:0] o_term
);

    logic signed [11:0] w_recip;
    logic signed [20:0] w_product;
    logic signed [20:0] w_shifted;

    assign w_recip   = 12'(RECIP[i_harmIdx]);
    assign w_product = i_lutData * w_recip;
    assign w_shifted = w_product >>> 10;
    assign o_term    = 16'(w_shifted);

endmodule

// File: rtl/fourier_harmonic_sequencer.sv
// Sums odd sine harmonics (square-wave approximation) from an external LUT, one sample per start.
module fourier_harmonic_sequencer #(
    parameter int PHASE_WIDTH = 16,
    parameter int PHASE_STEP  = 256,
    parameter int NUM_HARM    = 4,
    parameter int LUT_BITS    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                lut_rd_en,
    output logic [LUT_BITS-1:0] lut_addr,
    input  logic signed [8:0]   lut_data,
    output logic [7:0]          sample_out,
    output logic                sample_valid,
    output logic                overrun
);
    import fourier_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_HARM - 1);

    state_t                   r_state;
    logic [PHASE_WIDTH-1:0]   r_phase;
    logic [PHASE_WIDTH-1:0]   r_harmPhase;
    logic [PHASE_WIDTH-1:0]   r_twicePhase;
    logic [3:0]               r_issueIdx;
    logic [3:0]               r_termIdx;
    logic                     r_termValid;
    logic signed [15:0]       r_acc;
    logic                     r_busy;
    logic                     r_lutRdEn;
    logic [LUT_BITS-1:0]      r_lutAddr;
    logic [7:0]               r_sampleOut;
    logic                     r_sampleValid;
    logic                     r_overrun;

    logic signed [15:0]       w_term;
    logic signed [15:0]       w_accNext;
    int                       w_scaled;
    int                       w_norm;
    logic [7:0]               w_clamped;

    fourier_term_scaler u_scaler (
        .i_lutData (lut_data),
        .i_harmIdx (r_termIdx),
        .o_term    (w_term)
    );

    // The accumulator runs one cycle behind the issue, so DRAIN's value already includes the last term.
    always_comb begin
        w_accNext = r_termValid ? r_acc + w_term : r_acc;
        w_scaled  = (int'(w_accNext) * NORM_GAIN) >>> NORM_SHIFT;
        w_norm    = w_scaled + OUT_OFFSET;
        if (w_norm < 0)
            w_clamped = 8'd0;
        else if (w_norm > 255)
            w_clamped = 8'd255;
        else
            w_clamped = w_norm[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_phase       <= '0;
            r_harmPhase   <= '0;
            r_twicePhase  <= '0;
            r_issueIdx    <= '0;
            r_termIdx     <= '0;
            r_termValid   <= 1'b0;
            r_acc         <= '0;
            r_busy        <= 1'b0;
            r_lutRdEn     <= 1'b0;
            r_lutAddr     <= '0;
            r_sampleOut   <= 8'(OUT_RESET);
            r_sampleValid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sampleValid <= 1'b0;
            r_termValid   <= r_lutRdEn;
            r_termIdx     <= r_issueIdx;
            if (r_termValid)
                r_acc <= w_accNext;
            if (start && (r_state == RUN || r_state == DRAIN))
                r_overrun <= 1'b1;

            case (r_state)
                IDLE, OUT: begin
                    if (start) begin
                        r_state      <= RUN;
                        r_phase      <= r_phase + PHASE_WIDTH'(PHASE_STEP);
                        r_twicePhase <= r_phase << 1;
                        r_harmPhase  <= r_phase + (r_phase << 1);
                        r_lutAddr    <= r_phase[PHASE_WIDTH-1 -: LUT_BITS];
                        r_lutRdEn    <= 1'b1;
                        r_issueIdx   <= '0;
                        r_busy       <= 1'b1;
                        r_acc        <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_issueIdx == LAST_IDX) begin
                        r_state   <= DRAIN;
                        r_lutRdEn <= 1'b0;
                    end else begin
                        r_issueIdx  <= r_issueIdx + 4'd1;
                        r_lutAddr   <= r_harmPhase[PHASE_WIDTH-1 -: LUT_BITS];
                        r_harmPhase <= r_harmPhase + r_twicePhase;
                    end
                end
                DRAIN: begin
                    r_state       <= OUT;
                    r_busy        <= 1'b0;
                    r_sampleOut   <= w_clamped;
                    r_sampleValid <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign lut_rd_en    = r_lutRdEn;
    assign lut_addr     = r_lutAddr;
    assign sample_out   = r_sampleOut;
    assign sample_valid = r_sampleValid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fourier_harmonic_sequencer.sv
// Directed bench for the harmonic sequencer: three instances (1, 3 and 4 harmonics) with LUT stubs.
module tb_fourier_harmonic_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start1, start3, start4;

    logic               busy1, rdEn1, valid1, ovr1;
    logic [11:0]        addr1;
    logic [7:0]         out1;
    logic signed [8:0]  data1;

    logic               busy3, rdEn3, valid3, ovr3;
    logic [11:0]        addr3;
    logic [7:0]         out3;
    logic signed [8:0]  data3;

    logic               busy4, rdEn4, valid4, ovr4;
    logic [11:0]        addr4;
    logic [7:0]         out4;
    logic signed [8:0]  data4;

    int vectorsApplied = 0;
    int miscompares    = 0;

    always #5 clk = ~clk;

    fourier_harmonic_sequencer #(.NUM_HARM(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .lut_rd_en(rdEn1),
        .lut_addr(addr1), .lut_data(data1), .sample_out(out1),
        .sample_valid(valid1), .overrun(ovr1)
    );

    fourier_harmonic_sequencer #(.NUM_HARM(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .lut_rd_en(rdEn3),
        .lut_addr(addr3), .lut_data(data3), .sample_out(out3),
        .sample_valid(valid3), .overrun(ovr3)
    );

    fourier_harmonic_sequencer #(.NUM_HARM(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .lut_rd_en(rdEn4),
        .lut_addr(addr4), .lut_data(data4), .sample_out(out4),
        .sample_valid(valid4), .overrun(ovr4)
    );

    // Registered LUT stubs return zero unless read, so a mistimed accumulate shows up in the sum.
    always @(posedge clk) begin
        data3 <= rdEn3 ? 9'sd100 : 9'sd0;
        data4 <= rdEn4 ? 9'sd64 : 9'sd0;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s1, input logic s3, input logic s4, input logic r);
        start1 = s1;
        start3 = s3;
        start4 = s4;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int addrTable [9] = '{0, 0, 0, 16, 48, 80, 32, 96, 160};
        int waited;
        int timeouts;
        int sawValid;

        data1 = 9'sd255;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rst_busy", busy4, 0);
        checkOutput("rst_rden", rdEn4, 0);
        checkOutput("rst_addr", addr4, 0);
        checkOutput("rst_out", out4, 128);
        checkOutput("rst_valid", valid4, 0);
        checkOutput("rst_ovr", ovr4, 0);
        checkOutput("rst_out1", out1, 128);

        // One harmonic, full-scale positive then full-scale negative LUT data.
        for (int pass = 0; pass < 2; pass++) begin
            data1 = (pass == 0) ? 9'sd255 : -9'sd256;
            applyStimulus(1, 0, 0, 0);
            checkOutput("h1_rden_t1", rdEn1, 1);
            checkOutput("h1_busy_t1", busy1, 1);
            if (pass == 0) checkOutput("h1_addr_t1", addr1, 0);
            applyStimulus(0, 0, 0, 0);
            checkOutput("h1_rden_t2", rdEn1, 0);
            checkOutput("h1_valid_t2", valid1, 0);
            applyStimulus(0, 0, 0, 0);
            checkOutput("h1_valid_t3", valid1, 1);
            checkOutput("h1_busy_t3", busy1, 0);
            checkOutput("h1_out", out1, (pass == 0) ? 159 : 80);
            applyStimulus(0, 0, 0, 0);
            checkOutput("h1_valid_t4", valid1, 0);
        end

        // Three harmonics, three samples at phase 0, 256, 512.
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 1, 0, 0);
            for (int i = 0; i < 3; i++) begin
                if (i > 0) applyStimulus(0, 0, 0, 0);
                checkOutput("h3_rden", rdEn3, 1);
                checkOutput("h3_addr", addr3, addrTable[s*3 + i]);
            end
            applyStimulus(0, 0, 0, 0);
            checkOutput("h3_drain_rden", rdEn3, 0);
            checkOutput("h3_drain_busy", busy3, 1);
            checkOutput("h3_addr_hold", addr3, addrTable[s*3 + 2]);
            applyStimulus(0, 0, 0, 0);
            checkOutput("h3_valid", valid3, 1);
            checkOutput("h3_out", out3, 143);
            applyStimulus(0, 0, 0, 0);
            checkOutput("h3_valid_off", valid3, 0);
        end

        // Start held high: back-to-back samples every 6 cycles, overrun from the first RUN cycle.
        applyStimulus(0, 0, 0, 1);
        for (int k = 1; k < 20; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("held_valid", valid4, (k % 6 == 0) ? 1 : 0);
            checkOutput("held_busy", busy4, (k % 6 != 0) ? 1 : 0);
            checkOutput("held_ovr", ovr4, (k >= 2) ? 1 : 0);
            if (k == 6) checkOutput("held_out", out4, 136);
            if (k == 7) checkOutput("held_addr2", addr4, 16);
        end
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0);

        // Reset during a computation aborts it without a sample.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_rden_t2", rdEn4, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_valid", valid4, 0);
        checkOutput("abort_busy", busy4, 0);
        checkOutput("abort_rden", rdEn4, 0);
        checkOutput("abort_addr", addr4, 0);
        checkOutput("abort_out", out4, 128);
        checkOutput("abort_ovr", ovr4, 0);
        sawValid = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (valid4) sawValid++;
        end
        checkOutput("abort_no_valid", sawValid, 0);

        // Phase wrap: the 257th sample starts again at phase 0.
        applyStimulus(0, 0, 0, 1);
        timeouts = 0;
        for (int n = 1; n <= 257; n++) begin
            applyStimulus(0, 0, 1, 0);
            if (n == 256) checkOutput("wrap_addr_256", addr4, 4080);
            if (n == 257) checkOutput("wrap_addr_257", addr4, 0);
            waited = 0;
            while (!valid4 && waited < 12) begin
                applyStimulus(0, 0, 0, 0);
                waited++;
            end
            if (!valid4) timeouts++;
        end
        checkOutput("wrap_timeouts", timeouts, 0);
        checkOutput("wrap_out", out4, 136);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
